// File: rtl/estagio_busca.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding fetches and
// presents each word with its PC in the IF/ID register, with stall, redirect and flush.
module estagio_busca #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        desvio_tomado,
  input  logic [31:0] alvo_desvio,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instrucao,
  output logic [31:0] pc_saida,
  output logic        valido,
  output logic [31:0] contador_busca
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PASSO_PC = XLEN'(4);
  localparam logic [XLEN-1:0] MASCARA_ALINHA = ~XLEN'(3);

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    REQ      = 2'd1,
    HOLD     = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

  estado_t         estado, estado_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] buf_instr, buf_instr_n;
  logic [XLEN-1:0] buf_pc, buf_pc_n;
  logic [XLEN-1:0] instrucao_n, pc_saida_n, contador_n, mem_addr_n;
  logic            valido_n, mem_req_n;
  logic            slot_livre, consumido;
  logic [XLEN-1:0] alvo_alinhado;

  assign slot_livre    = ~valido | ~stall;
  assign consumido     = valido & ~stall;
  assign alvo_alinhado = alvo_desvio & MASCARA_ALINHA;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= INICIO;
      pc             <= RESET_PC;
      buf_instr      <= '0;
      buf_pc         <= '0;
      instrucao      <= NOP;
      pc_saida       <= '0;
      valido         <= 1'b0;
      contador_busca <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= RESET_PC;
    end else begin
      estado         <= estado_n;
      pc             <= pc_n;
      buf_instr      <= buf_instr_n;
      buf_pc         <= buf_pc_n;
      instrucao      <= instrucao_n;
      pc_saida       <= pc_saida_n;
      valido         <= valido_n;
      contador_busca <= contador_n;
      mem_req        <= mem_req_n;
      mem_addr       <= mem_addr_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_n    = estado;
    pc_n        = pc;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    instrucao_n = instrucao;
    pc_saida_n  = pc_saida;
    valido_n    = valido;
    contador_n  = contador_busca;

    case (estado)
      INICIO: begin
        estado_n = REQ;
      end

      REQ: begin
        if (desvio_tomado) begin
          pc_n        = alvo_alinhado;
          valido_n    = 1'b0;
          instrucao_n = NOP;
          buf_instr_n = '0;
          buf_pc_n    = '0;
          estado_n    = mem_ack ? REQ : DESCARTE;
        end else if (mem_ack) begin
          pc_n = pc + PASSO_PC;
          if (slot_livre) begin
            instrucao_n = mem_rdata;
            pc_saida_n  = pc;
            valido_n    = 1'b1;
            contador_n  = contador_busca + XLEN'(1);
          end else begin
            buf_instr_n = mem_rdata;
            buf_pc_n    = pc;
            estado_n    = HOLD;
          end
        end else if (consumido) begin
          valido_n    = 1'b0;
          instrucao_n = NOP;
        end
      end

      HOLD: begin
        if (desvio_tomado) begin
          pc_n        = alvo_alinhado;
          valido_n    = 1'b0;
          instrucao_n = NOP;
          buf_instr_n = '0;
          buf_pc_n    = '0;
          estado_n    = REQ;
        end else if (!stall) begin
          instrucao_n = buf_instr;
          pc_saida_n  = buf_pc;
          valido_n    = 1'b1;
          contador_n  = contador_busca + XLEN'(1);
          estado_n    = REQ;
        end
      end

      DESCARTE: begin
        // Response to the abandoned address is swallowed; only the PC may move
        if (desvio_tomado) begin
          pc_n        = alvo_alinhado;
          valido_n    = 1'b0;
          instrucao_n = NOP;
        end
        if (mem_ack) begin
          estado_n = REQ;
        end
      end

      default: begin
        estado_n = INICIO;
      end
    endcase

    mem_req_n  = (estado_n == REQ) || (estado_n == DESCARTE);
    // In DESCARTE the bus keeps the old address until the ack arrives
    mem_addr_n = (estado_n == DESCARTE) ? mem_addr : pc_n;
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: memory answers with a word derived from
// the address so instruction/PC pairing can be verified.
module tb_estagio_busca;

  localparam logic [31:0] NOP_W = 32'h00000013;
  localparam logic [31:0] CHAVE = 32'h5A000000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        desvio_tomado;
  logic [31:0] alvo_desvio;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instrucao;
  logic [31:0] pc_saida;
  logic        valido;
  logic [31:0] contador_busca;

  int vetores;
  int erros;

  estagio_busca #(
    .RESET_PC(32'h00000000),
    .NOP     (32'h00000013)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .desvio_tomado (desvio_tomado),
    .alvo_desvio   (alvo_desvio),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instrucao     (instrucao),
    .pc_saida      (pc_saida),
    .valido        (valido),
    .contador_busca(contador_busca)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem_addr ^ CHAVE;

  function automatic logic [31:0] dado(input logic [31:0] a);
    return a ^ CHAVE;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    assert (obs === esp) else begin
      erros++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, esp);
    end
  endtask

  task automatic chk_saida(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] cnt);
    chk({tag, ".valido"}, 32'(valido), 32'(v));
    chk({tag, ".pc_saida"}, pc_saida, pc);
    chk({tag, ".instrucao"}, instrucao, ins);
    chk({tag, ".contador"}, contador_busca, cnt);
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(req));
    if (req) chk({tag, ".mem_addr"}, mem_addr, addr);
  endtask

  initial begin
    vetores       = 0;
    erros         = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    desvio_tomado = 1'b0;
    alvo_desvio   = 32'h0;
    mem_ack       = 1'b0;

    // Reset state
    tick();
    chk_mem("rst_a", 1'b0, 32'h0);
    tick();
    chk_mem("rst_b", 1'b0, 32'h0);
    chk_saida("rst", 1'b0, 32'h0, NOP_W, 32'd0);

    // First request one cycle after reset release, then streaming fetch
    reset   = 1'b0;
    mem_ack = 1'b1;
    tick();
    chk_mem("inicio", 1'b1, 32'h0);
    chk("inicio.valido", 32'(valido), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_saida("stream", 1'b1, 32'(4 * i), dado(32'(4 * i)), 32'(i + 1));
      chk_mem("stream", 1'b1, 32'(4 * (i + 1)));
    end

    // Stall for 3 cycles while the ack for 20 arrives: word 20 goes to the buffer
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_saida("hold", 1'b1, 32'd16, dado(32'd16), 32'd5);
      chk_mem("hold", 1'b0, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk_saida("hold_rel", 1'b1, 32'd20, dado(32'd20), 32'd6);
    chk_mem("hold_rel", 1'b1, 32'd24);
    tick();
    chk_saida("resume", 1'b1, 32'd24, dado(32'd24), 32'd7);
    chk_mem("resume", 1'b1, 32'd28);

    // Redirect to 0x103 while valid and with an ack in the same cycle
    desvio_tomado = 1'b1;
    alvo_desvio   = 32'h00000103;
    tick();
    desvio_tomado = 1'b0;
    chk_saida("redir", 1'b0, 32'd24, NOP_W, 32'd7);
    chk_mem("redir", 1'b1, 32'h00000100);
    tick();
    chk_saida("redir_tgt", 1'b1, 32'h100, dado(32'h100), 32'd8);
    chk_mem("redir_tgt", 1'b1, 32'h104);

    // Redirect while the request for 0x104 is outstanding
    mem_ack = 1'b0;
    tick();
    chk_saida("wait", 1'b0, 32'h100, NOP_W, 32'd8);
    chk_mem("wait", 1'b1, 32'h104);
    desvio_tomado = 1'b1;
    alvo_desvio   = 32'h00000200;
    tick();
    desvio_tomado = 1'b0;
    chk_mem("desc_a", 1'b1, 32'h104);
    tick();
    chk_mem("desc_b", 1'b1, 32'h104);
    tick();
    chk_mem("desc_c", 1'b1, 32'h104);
    mem_ack = 1'b1;
    tick();
    chk_saida("desc_drop", 1'b0, 32'h100, NOP_W, 32'd8);
    chk_mem("desc_drop", 1'b1, 32'h200);
    tick();
    chk_saida("desc_tgt", 1'b1, 32'h200, dado(32'h200), 32'd9);
    chk_mem("desc_tgt", 1'b1, 32'h204);

    // Redirect together with stall and ack: data dropped, redirect wins
    stall         = 1'b1;
    desvio_tomado = 1'b1;
    alvo_desvio   = 32'h00000300;
    tick();
    stall         = 1'b0;
    desvio_tomado = 1'b0;
    chk_saida("redir_stall", 1'b0, 32'h200, NOP_W, 32'd9);
    chk_mem("redir_stall", 1'b1, 32'h300);
    tick();
    chk_saida("redir_stall_tgt", 1'b1, 32'h300, dado(32'h300), 32'd10);

    // Deliver the last word of the address space: PC wraps to 0
    desvio_tomado = 1'b1;
    alvo_desvio   = 32'hFFFFFFFF;
    tick();
    desvio_tomado = 1'b0;
    chk_mem("wrap_req", 1'b1, 32'hFFFFFFFC);
    tick();
    chk_saida("wrap", 1'b1, 32'hFFFFFFFC, dado(32'hFFFFFFFC), 32'd11);
    chk_mem("wrap", 1'b1, 32'h0);

    // Enter HOLD with pc=0xFFFFFFFC, then reset mid-HOLD
    desvio_tomado = 1'b1;
    alvo_desvio   = 32'hFFFFFFF4;
    tick();
    desvio_tomado = 1'b0;
    tick();
    chk_saida("pre_hold", 1'b1, 32'hFFFFFFF4, dado(32'hFFFFFFF4), 32'd12);
    chk_mem("pre_hold", 1'b1, 32'hFFFFFFF8);
    stall = 1'b1;
    tick();
    chk_mem("hold2", 1'b0, 32'h0);
    chk_saida("hold2", 1'b1, 32'hFFFFFFF4, dado(32'hFFFFFFF4), 32'd12);
    reset = 1'b1;
    tick();
    chk_saida("rst_hold", 1'b0, 32'h0, NOP_W, 32'd0);
    chk_mem("rst_hold", 1'b0, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    tick();
    chk_mem("post_rst", 1'b1, 32'h0);
    chk("post_rst.valido", 32'(valido), 32'h0);
    tick();
    chk_saida("post_rst_dlv", 1'b1, 32'h0, dado(32'h0), 32'd1);
    chk_mem("post_rst_dlv", 1'b1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
Instruction-fetch stage feeding the immediate generator and decoder. It holds the PC, issues single-outstanding requests to instruction memory and presents each fetched word with its PC in an IF/ID output register. It supports downstream stall, taken-branch redirect with flush, and discard of in-flight responses after a redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] must be 0)
NOP, 32'h00000013, instruction word presented while the output is empty (addi x0,x0,0)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clock
stall  in  1  downstream cannot accept; hold the output register
desvio_tomado  in  1  taken branch/jump redirect, one-cycle pulse
alvo_desvio  in  32  redirect target; bits [1:0] ignored, forced to 0
mem_req  out  1  instruction memory request
mem_addr  out  32  request address, word aligned
mem_ack  in  1  response valid; meaningful only while mem_req=1
mem_rdata  in  32  instruction word, valid with mem_ack
instrucao  out  32  IF/ID instruction
pc_saida  out  32  IF/ID PC of instrucao
valido  out  1  IF/ID entry valid
contador_busca  out  32  count of instructions delivered to IF/ID

Behaviour:
- Output register is "consumed" on any edge where valido=1 and stall=0. The slot is "free" when valido=0 or stall=0.
- Reset (sync, highest priority):
  - pc=RESET_PC, state=INICIO, valido=0, instrucao=NOP, pc_saida=0, contador_busca=0.
  - Internal buffer is cleared.
  - mem_req=0 during reset and in INICIO.
- mem_req=1 exactly in states REQ and DESCARTE. mem_addr equals the internal pc in REQ and the latched old address in DESCARTE. Both are stable until mem_ack.
- INICIO: go to REQ on the next edge. The first mem_req appears 1 cycle after reset deasserts.
- REQ, mem_ack=1, slot free:
  - instrucao=mem_rdata, pc_saida=pc, valido=1, contador_busca+1, pc=pc+4.
  - Stay in REQ. The next request is issued back-to-back on the following cycle.
- REQ, mem_ack=1, slot not free: store mem_rdata and pc in the buffer, pc=pc+4, go to HOLD.
- REQ, mem_ack=0: stay in REQ. If valido=1 and stall=0, clear valido and set instrucao=NOP.
- HOLD: mem_req=0. When stall=0, move the buffer to the output (valido=1, contador_busca+1) and go to REQ.
- Redirect (desvio_tomado=1) beats stall and is handled in any state except INICIO:
  - pc = {alvo_desvio[31:2],2'b00}; valido=0; instrucao=NOP; buffer discarded.
  - In REQ with mem_ack=0: latch the old address and go to DESCARTE. The request stays asserted until mem_ack, the data is dropped, then go to REQ.
  - In REQ with mem_ack=1 in the same cycle: drop the data and go to REQ (new pc issued next cycle).
  - In HOLD: go to REQ.
  - In DESCARTE: update pc only and keep waiting for the ack.
- DESCARTE responses never reach the output and never increment contador_busca.
- pc+4 and contador_busca wrap modulo 2^32 without a flag.
- Fetch latency: with mem_ack returned in the same cycle as mem_req, valido rises 1 cycle after the request. Sustained throughput is 1 instruction/cycle when stall=0.

Test Plan:
- Reset then mem_ack tied 1, mem_rdata=addr -> mem_addr sequence 0,4,8…; valido high from cycle 2; pc_saida=instrucao; contador_busca=5 after 5 deliveries.
- stall held 3 cycles with an ack arriving -> output holds; mem_req=0 in HOLD; after release, the buffered word is presented and then fetch resumes at pc+4 with no word lost or duplicated.
- desvio_tomado with alvo_desvio=32'h00000103 while valido=1 -> next edge valido=0, instrucao=32'h00000013; next mem_addr=32'h00000100.
- Redirect while a request is outstanding (mem_ack delayed 3 cycles) -> mem_addr holds the old value until ack; that data is dropped and contador_busca is unchanged; then mem_addr=target.
- Redirect in the same cycle as mem_ack, and simultaneously with stall=1 -> data dropped, valido=0, redirect taken.
- Reset asserted mid-HOLD with pc=32'hFFFFFFFC -> all outputs return to reset values; the first request after reset is at RESET_PC.
- Separately, deliver the word at pc=32'hFFFFFFFC -> pc wraps to 0.
